// File: rtl/bpu_pkg.sv
// Shared predictor definitions: bimodal counter encodings, entry field widths
// and the next-state function used by both this controller and the PS RAM.
package bpu_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] pred_state_t;

    localparam pred_state_t PRED_STRONG_NT = 2'b00;
    localparam pred_state_t PRED_WEAK_NT   = 2'b01;
    localparam pred_state_t PRED_WEAK_T    = 2'b10;
    localparam pred_state_t PRED_STRONG_T  = 2'b11;

    // An unpredicted entry restarts at the weak state matching the outcome.
    function automatic pred_state_t bpu_next_state(input logic was_pred,
                                                   input pred_state_t state,
                                                   input logic taken);
        if (!was_pred) return {taken, !taken};
        if (taken) return (state == PRED_STRONG_T) ? PRED_STRONG_T : state + 2'd1;
        return (state == PRED_STRONG_NT) ? PRED_STRONG_NT : state - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_update_ctrl_if.sv
// Fetch-push, resolve-pop and predictor-update signals of bpu_update_ctrl.
interface bpu_update_ctrl_if
    import bpu_pkg::*;
#(
    parameter int PS_SIZE = 8,
    parameter int Q_SIZE  = 2
);
    logic               fch_push;
    logic [PS_SIZE-1:0] fch_ps_addr;
    pred_state_t        fch_pred_state;
    logic               fch_was_pred;
    logic               q_full;
    logic [Q_SIZE:0]    q_count;
    logic               res_valid;
    logic               res_is_branch;
    logic               res_taken;
    logic               res_flush;
    logic               wrb_update_bpu;
    logic               wrb_was_pred;
    pred_state_t        wrb_ps_state;
    logic [PS_SIZE-1:0] wrb_ps_addr;
    logic               wrb_direction;
    logic               q_err;

    modport master (
        output fch_push, fch_ps_addr, fch_pred_state, fch_was_pred,
        output res_valid, res_is_branch, res_taken, res_flush,
        input  q_full, q_count, q_err,
        input  wrb_update_bpu, wrb_was_pred, wrb_ps_state, wrb_ps_addr, wrb_direction
    );

    modport slave (
        input  fch_push, fch_ps_addr, fch_pred_state, fch_was_pred,
        input  res_valid, res_is_branch, res_taken, res_flush,
        output q_full, q_count, q_err,
        output wrb_update_bpu, wrb_was_pred, wrb_ps_state, wrb_ps_addr, wrb_direction
    );
endinterface

// File: rtl/bpu_meta_fifo.sv
// Circular queue of fetch-time prediction metadata with a broadcast
// address-compare port that rewrites the state of every matching entry.
module bpu_meta_fifo
    import bpu_pkg::*;
#(
    parameter int PS_SIZE = 8,
    parameter int Q_SIZE  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [PS_SIZE-1:0] push_addr,
    input  pred_state_t        push_state,
    input  logic               push_was_pred,
    input  logic               pop,
    input  logic               flush,
    input  logic               fwd_en,
    input  logic [PS_SIZE-1:0] fwd_addr,
    input  pred_state_t        fwd_state,
    output logic [PS_SIZE-1:0] head_addr,
    output pred_state_t        head_state,
    output logic               head_was_pred,
    output logic [Q_SIZE:0]    count,
    output logic               full,
    output logic               empty
);
    localparam int                DEPTH     = 1 << Q_SIZE;
    localparam logic [Q_SIZE:0]   DEPTH_CNT = DEPTH[Q_SIZE:0];
    localparam logic [Q_SIZE-1:0] PTR_ONE   = 1;
    localparam logic [Q_SIZE:0]   CNT_ONE   = 1;

    logic [Q_SIZE-1:0]  head_q, head_d, tail_q, tail_d;
    logic [Q_SIZE:0]    count_q, count_d;
    logic [PS_SIZE-1:0] addr_q  [DEPTH];
    logic [PS_SIZE-1:0] addr_d  [DEPTH];
    pred_state_t        state_q [DEPTH];
    pred_state_t        state_d [DEPTH];
    logic               wp_q    [DEPTH];
    logic               wp_d    [DEPTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_ONE;
            if (pop)  head_d = head_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Stale slots may also match; their contents are don't-care, so no valid mask is needed.
    always_comb begin
        addr_d  = addr_q;
        state_d = state_q;
        wp_d    = wp_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail_q == Q_SIZE'(i)) begin
                addr_d[i]  = push_addr;
                state_d[i] = push_state;
                wp_d[i]    = push_was_pred;
            end else if (fwd_en && addr_q[i] == fwd_addr) begin
                state_d[i] = fwd_state;
                wp_d[i]    = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        state_q <= state_d;
        wp_q    <= wp_d;
    end

    assign head_addr     = addr_q[head_q];
    assign head_state    = state_q[head_q];
    assign head_was_pred = wp_q[head_q];
    assign count         = count_q;
    assign full          = (count_q == DEPTH_CNT);
    assign empty         = (count_q == '0);

endmodule

// File: rtl/bpu_update_ctrl.sv
// Writeback-side predictor update: pops fetch metadata on resolution, issues the
// registered PS write and forwards in-flight updates into younger entries.
module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int PS_SIZE = 8,
    parameter int Q_SIZE  = 2
) (
    input logic              clk,
    input logic              reset,
    bpu_update_ctrl_if.slave bus
);
    logic [PS_SIZE-1:0] head_addr;
    pred_state_t        head_state;
    logic               head_was_pred;
    logic [Q_SIZE:0]    count;
    logic               full, empty;

    logic               pop, upd, push_acc, fifo_pop;
    pred_state_t        upd_state, wrb_next, push_state;
    logic               push_was_pred;

    logic               upd_q, upd_d, wp_q, wp_d, dir_q, dir_d, err_q, err_d;
    logic [PS_SIZE-1:0] addr_q, addr_d;
    pred_state_t        state_q, state_d;

    always_comb begin
        pop       = bus.res_valid && !empty;
        upd       = pop && bus.res_is_branch;
        upd_state = bpu_next_state(head_was_pred, head_state, bus.res_taken);
        fifo_pop  = pop && !bus.res_flush;
        push_acc  = bus.fch_push && !bus.res_flush && (!full || pop);
        wrb_next  = bpu_next_state(wp_q, state_q, dir_q);

        // The current pop is newer than the update already on the wrb_* bus.
        push_state    = bus.fch_pred_state;
        push_was_pred = bus.fch_was_pred;
        if (upd && bus.fch_ps_addr == head_addr) begin
            push_state    = upd_state;
            push_was_pred = 1'b1;
        end else if (upd_q && bus.fch_ps_addr == addr_q) begin
            push_state    = wrb_next;
            push_was_pred = 1'b1;
        end

        err_d = err_q
              | (bus.fch_push && !bus.res_flush && full && !pop)
              | (bus.res_valid && empty);

        upd_d   = upd;
        addr_d  = addr_q;
        state_d = state_q;
        wp_d    = wp_q;
        dir_d   = dir_q;
        if (upd) begin
            addr_d  = head_addr;
            state_d = head_state;
            wp_d    = head_was_pred;
            dir_d   = bus.res_taken;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_q   <= 1'b0;
            addr_q  <= '0;
            state_q <= '0;
            wp_q    <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            upd_q   <= upd_d;
            addr_q  <= addr_d;
            state_q <= state_d;
            wp_q    <= wp_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    bpu_meta_fifo #(.PS_SIZE(PS_SIZE), .Q_SIZE(Q_SIZE)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (push_acc),
        .push_addr     (bus.fch_ps_addr),
        .push_state    (push_state),
        .push_was_pred (push_was_pred),
        .pop           (fifo_pop),
        .flush         (bus.res_flush),
        .fwd_en        (upd),
        .fwd_addr      (head_addr),
        .fwd_state     (upd_state),
        .head_addr     (head_addr),
        .head_state    (head_state),
        .head_was_pred (head_was_pred),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    assign bus.q_full         = full;
    assign bus.q_count        = count;
    assign bus.q_err          = err_q;
    assign bus.wrb_update_bpu = upd_q;
    assign bus.wrb_ps_addr    = addr_q;
    assign bus.wrb_ps_state   = state_q;
    assign bus.wrb_was_pred   = wp_q;
    assign bus.wrb_direction  = dir_q;

endmodule
